// File: rtl/note_player_pkg.sv
// ============================================================================
// note_player_pkg
// Shared types, state encodings and the note half-period table for playback.
// Revision: 1.0
// ============================================================================
`default_nettype none

package note_player_pkg;

    localparam int NUM_STRINGS = 6;
    localparam int NUM_FRETS   = 5;
    localparam int HP_W        = 19;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_FETCH   = 3'd1;
    localparam logic [2:0] ENC_CAPTURE = 3'd2;
    localparam logic [2:0] ENC_PLAY    = 3'd3;
    localparam logic [2:0] ENC_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_FETCH   = ENC_FETCH,
        ST_CAPTURE = ENC_CAPTURE,
        ST_PLAY    = ENC_PLAY,
        ST_DONE    = ENC_DONE
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] fret;
    } fret_sel_t;

    typedef logic [NUM_STRINGS*NUM_FRETS-1:0][HP_W-1:0] hp_tab_t;

    // Note frequencies in milli-hertz: open strings E2 A2 D3 G3 B3 E4, semitone per fret.
    function automatic longint note_freq_mhz(input int idx);
        case (idx)
            0:  return 82410;   1:  return 87310;   2:  return 92502;
            3:  return 98003;   4:  return 103830;
            5:  return 110000;  6:  return 116541;  7:  return 123471;
            8:  return 130813;  9:  return 138591;
            10: return 146830;  11: return 155561;  12: return 164811;
            13: return 174611;  14: return 184994;
            15: return 196000;  16: return 207655;  17: return 220003;
            18: return 233085;  19: return 246945;
            20: return 246940;  21: return 261624;  22: return 277181;
            23: return 293663;  24: return 311125;
            25: return 329630;  26: return 349231;  27: return 369997;
            28: return 391998;  29: return 415308;
            default: return 1000000;
        endcase
    endfunction

    // Rounded clk_hz / (2 * f), indexed by string*NUM_FRETS + fret.
    function automatic hp_tab_t build_hp_tab(input longint clk_hz);
        hp_tab_t tab;
        longint  fm;
        longint  hp;
        tab = '0;
        for (int i = 0; i < NUM_STRINGS*NUM_FRETS; i++) begin
            fm     = note_freq_mhz(i);
            hp     = (clk_hz * 1000 + fm) / (2 * fm);
            tab[i] = hp[HP_W-1:0];
        end
        return tab;
    endfunction

    // Highest set fret on string s wins; no bit set means the string is silent.
    function automatic fret_sel_t pick_fret(input logic [29:0] word, input int s);
        fret_sel_t   sel;
        logic [29:0] sh;
        sel = '0;
        for (int f = 0; f < NUM_FRETS; f++) begin
            sh = word >> (NUM_STRINGS*f + s);
            if (sh[0]) begin
                sel.hit  = 1'b1;
                sel.fret = 3'(f);
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_player_if.sv
// ============================================================================
// note_player_if
// Note RAM read port and audio codec FIFO handshake bundled for note_player.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface note_player_if;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        audio_out_allowed;
    logic [31:0] left_sample;
    logic [31:0] right_sample;
    logic        write_audio_out;

    modport master (
        output rd_addr, left_sample, right_sample, write_audio_out,
        input  rd_data, audio_out_allowed
    );

    modport slave (
        input  rd_addr, left_sample, right_sample, write_audio_out,
        output rd_data, audio_out_allowed
    );
endinterface

`default_nettype wire

// File: rtl/note_player_tone_voice.sv
// ============================================================================
// note_player_tone_voice
// Square-wave voice: toggles phase every half_period enabled clocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module note_player_tone_voice
    import note_player_pkg::*;
(
    input  wire             clk,
    input  wire             resetn,
    input  wire             reload,
    input  wire             enable,
    input  wire [HP_W-1:0]  half_period,
    output logic            phase
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (reload) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (enable) begin
            if (cnt_q == half_period - HP_W'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + HP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/note_player.sv
// ============================================================================
// note_player
// Steps through the note RAM per beat, drives six voices and paces mixed samples.
// Revision: 1.0
// ============================================================================
`default_nettype none

module note_player
    import note_player_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SAMPLE_DIV = 1042,
    parameter int AMP        = 10_000_000
) (
    input  wire              clk,
    input  wire              resetn,
    input  wire              start,
    input  wire              stop,
    input  wire              beat_tick,
    input  wire  [6:0]       play_len,
    note_player_if.master    bus,
    output logic             playing,
    output logic             done
);

    localparam int                 c_sc_w   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic signed [31:0] c_amp    = 32'(AMP);
    localparam hp_tab_t            c_hp_tab = build_hp_tab(longint'(CLK_HZ));

    state_t            state_q, state_d;
    logic [5:0]        rd_addr_q, rd_addr_d;
    logic [6:0]        beat_cnt_q, beat_cnt_d;
    logic [NUM_STRINGS-1:0] active_q, active_d;
    logic [HP_W-1:0]   hp_q [NUM_STRINGS];
    logic [HP_W-1:0]   hp_d [NUM_STRINGS];
    logic [c_sc_w-1:0] scnt_q, scnt_d;
    logic              pending_q, pending_d;
    logic [31:0]       sample_q, sample_d;
    logic              wr_q, wr_d;

    logic [6:0]             w_len;
    logic                   w_reload;
    logic                   w_wrap;
    logic [NUM_STRINGS-1:0] w_hit;
    logic [HP_W-1:0]        w_hp_pick [NUM_STRINGS];
    logic [NUM_STRINGS-1:0] w_phase;
    logic signed [31:0]     w_mix;
    logic                   w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.rd_data[31:30]};
    assign w_len       = (play_len == 7'd0) ? 7'd64 : play_len;

    always_comb begin
        fret_sel_t sel;
        for (int s = 0; s < NUM_STRINGS; s++) begin
            sel          = pick_fret(bus.rd_data[29:0], s);
            w_hit[s]     = sel.hit;
            w_hp_pick[s] = c_hp_tab[s*NUM_FRETS];
            for (int f = 1; f < NUM_FRETS; f++) begin
                if (sel.fret == 3'(f)) begin
                    w_hp_pick[s] = c_hp_tab[s*NUM_FRETS + f];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        beat_cnt_d = beat_cnt_q;
        active_d   = active_q;
        hp_d       = hp_q;
        w_reload   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_FETCH;
                    rd_addr_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            ST_FETCH: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d  = ST_PLAY;
                w_reload = 1'b1;
                active_d = w_hit;
                hp_d     = w_hp_pick;
            end
            ST_PLAY: begin
                if (beat_tick) begin
                    beat_cnt_d = beat_cnt_q + 7'd1;
                    if (beat_cnt_q + 7'd1 == w_len) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + 6'd1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
        if (state_d == ST_IDLE) begin
            active_d = '0;
        end
    end

    generate
        for (genvar s = 0; s < NUM_STRINGS; s++) begin : g_voice
            note_player_tone_voice u_voice (
                .clk         (clk),
                .resetn      (resetn),
                .reload      (w_reload),
                .enable      (active_q[s]),
                .half_period (hp_q[s]),
                .phase       (w_phase[s])
            );
        end
    endgenerate

    always_comb begin
        w_mix = '0;
        for (int s = 0; s < NUM_STRINGS; s++) begin
            if (active_q[s]) begin
                w_mix = w_phase[s] ? (w_mix + c_amp) : (w_mix - c_amp);
            end
        end
    end

    assign w_wrap = (state_q != ST_IDLE) && (scnt_q == c_sc_w'(SAMPLE_DIV - 1));

    // A wrap takes priority over a write so the strobe never pairs with a sample just replaced.
    always_comb begin
        scnt_d    = scnt_q;
        pending_d = pending_q;
        sample_d  = sample_q;
        wr_d      = 1'b0;
        if (state_d == ST_IDLE) begin
            scnt_d    = '0;
            pending_d = 1'b0;
            sample_d  = '0;
        end else if (state_q != ST_IDLE) begin
            scnt_d = w_wrap ? '0 : scnt_q + c_sc_w'(1);
            if (w_wrap) begin
                pending_d = 1'b1;
                sample_d  = w_mix;
            end else if (pending_q && bus.audio_out_allowed) begin
                pending_d = 1'b0;
                wr_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            beat_cnt_q <= '0;
            active_q   <= '0;
            for (int s = 0; s < NUM_STRINGS; s++) begin
                hp_q[s] <= '0;
            end
            scnt_q     <= '0;
            pending_q  <= 1'b0;
            sample_q   <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            beat_cnt_q <= beat_cnt_d;
            active_q   <= active_d;
            hp_q       <= hp_d;
            scnt_q     <= scnt_d;
            pending_q  <= pending_d;
            sample_q   <= sample_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.rd_addr         = rd_addr_q;
    assign bus.left_sample     = sample_q;
    assign bus.right_sample    = sample_q;
    assign bus.write_audio_out = wr_q;
    assign playing             = (state_q != ST_IDLE);
    assign done                = (state_q == ST_DONE);

endmodule

`default_nettype wire
